fc_argmax: RTL

Sequential argmax stage downstream of the final fully-connected layer. It captures the vector of N_CLASS post-ReLU neuron outputs in a single handshake, then scans the captured scores one per cycle. It returns the winning class index and its score through a valid/ready output port. This stage turns the combinational classifier tree into a handshaked prediction.

---
 rtl/fc_argmax_pkg.sv | 7 +
 rtl/fc_argmax.sv | 62 ++++++
 2 files changed

// File: rtl/fc_argmax_pkg.sv
// fc_argmax_pkg: shared FSM state type and index-width helper
package fc_argmax_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fc_argmax.sv
// fc_argmax: captures a score vector, scans it one entry per cycle, returns argmax via valid/ready
module fc_argmax
  import fc_argmax_pkg::*;
#(
  parameter int N_CLASS = 10,
  parameter int IN_WIDTH = 23,
  localparam int IDX_W = idx_w(N_CLASS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] scores [0:N_CLASS-1],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_class,
  output logic [IN_WIDTH-1:0] out_score,
  output logic                busy
);
  state_t state, nxt;
  logic [IN_WIDTH-1:0] scores_q [0:N_CLASS-1];
  logic [IN_WIDTH-1:0] best_score;
  logic [IDX_W-1:0] best_idx, cnt;
  logic last, accept;
  assign last = cnt == IDX_W'(N_CLASS - 1);
  assign accept = in_valid && state == IDLE;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign out_class = best_idx;
  assign out_score = best_score;
  always_comb begin
    nxt = accept ? ((N_CLASS == 1) ? DONE : SCAN) :
          (state == SCAN && last) ? DONE :
          (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  // buffer contents are don't-care after reset, so it carries no reset
  always_ff @(posedge clk) begin
    if (accept) scores_q <= scores;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_score <= '0;
      best_idx <= '0;
      cnt <= '0;
    end else if (accept) begin
      best_score <= scores[0];
      best_idx <= '0;
      cnt <= IDX_W'(1);
    end else if (state == SCAN) begin
      if (scores_q[cnt] > best_score) begin
        best_score <= scores_q[cnt];
        best_idx <= cnt;
      end
      if (!last) cnt <= cnt + 1'b1;
    end
  end
endmodule
